pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
// - Parametrised inter-stage pipeline register for the MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries an opaque WIDTH-bit payload through DEPTH slots, with a valid/ready handshake.
// - Supports freeze (stall hold), flush (bubble insertion) and saturating stall/bubble counters.
// - Stages pack their control and data fields into the payload via pipe_pkg structs.
// PARAMETERS
// - WIDTH      32   payload bits per slot (1..512)
// - DEPTH      1    number of register slots in series (1..4)
// - RESET_VAL  '0   payload value loaded on reset and on flush
// - CNT_W      16   width of the stall/bubble performance counters
// PORTS
// - clk          in   1      core clock; all state updates on posedge
// - rst          in   1      synchronous, active-high reset
// - in_valid     in   1      upstream payload valid
// - in_ready     out  1      slot 0 can accept this cycle
// - in_data      in   WIDTH  upstream payload
// - freeze       in   1      hold all slots; no accept, no emit
// - flush        in   1      invalidate all slots next edge
// - out_valid    out  1      last slot holds a valid payload
// - out_ready    in   1      downstream accepts this cycle
// - out_data     out  WIDTH  last-slot payload
// - stall_cnt    out  CNT_W  cycles where out_valid && (!out_ready || freeze); saturating
// - bubble_cnt   out  CNT_W  cycles where !out_valid && !freeze; saturating
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - every slot valid=0 and payload=RESET_VAL.
//   - stall_cnt=0, bubble_cnt=0, out_valid=0, out_data=RESET_VAL.
//   - in_ready=0 during the reset cycle.
// - Slot i is a {valid, payload} pair; slot DEPTH-1 drives out_*.
// - Advance rule: rdy[DEPTH]=out_ready; rdy[i] = !freeze && (!v[i] || rdy[i+1]); in_ready = rdy[0] && !flush.
// - Transfer into slot i when rdy[i]; slot 0 loads {in_valid && in_ready, in_data}.
// - Latency: a payload accepted at edge N appears on out_data after edge N+DEPTH-1 (valid in that cycle) with no stalls.
// - Throughput: 1 payload/cycle at steady state.
// - Freeze:
//   - all slots and counters except stall_cnt hold.
//   - in_ready=0; out_valid stays asserted but the downstream must not consume.
//   - the transfer still counts as not taken even if out_ready=1.
// - Flush:
//   - all v[i] <= 0 and all payloads <= RESET_VAL at the next edge.
//   - in_ready=0, so a simultaneous in_valid is dropped; upstream must re-present.
// - Precedence: rst > flush > freeze > normal.
// - Simultaneous accept and emit on a full chain: both occur; occupancy unchanged; no bubble.
// - Counters saturate at 2^CNT_W-1 (no wrap); they are cleared only by rst, not by flush.
// - Reset mid-operation discards all in-flight payloads; there is no partial drain.
// - Payload is never modified; no width conversion; out_data is registered (no comb path from in_data).
// CONFIGURATION
// - Macro PIPE_STAGE_SKID_EN:
//   - Defined: a 1-entry skid buffer sits in front of slot 0. in_ready is a flop (=skid empty) with no
//     combinational path from out_ready/freeze. On a backpressure edge the skid captures one payload;
//     the skid drains before new input. Latency is unchanged when the skid is empty; flush also empties
//     the skid.
//   - Undefined: in_ready is combinational from out_ready/freeze/flush as above; no extra storage.
// STRUCTURE
// - pipe_pkg:
//   - stage payload structs: if_id_t, id_ex_t, ex_mem_t, mem_wb_t.
//   - PIPE_CNT_W_DEF.
//   - function pipe_sat_inc.
// - Sub-module pipe_stage_slot: one {valid, payload} slot with load/clear/hold; pipe_stage_reg instantiates
//   DEPTH of them in a generate loop and adds the ready chain, skid (optional) and counters.
// TESTING
// - DEPTH=1, WIDTH=32; in_data=0xDEADBEEF, in_valid=1, out_ready=1 -> out_valid=1 and out_data=0xDEADBEEF
//   one edge later; bubble_cnt=1 (the reset-release cycle).
// - DEPTH=3; stream 0..9 back-to-back, out_ready=1 -> first output 3 edges after first accept, then 1/cycle
//   in order, no gaps.
// - DEPTH=2 full; out_ready=0 for 5 cycles -> in_ready=0, out_data held, stall_cnt=5; release -> order preserved.
// - Payloads in flight; freeze=1 and flush=1 in the same cycle -> next cycle out_valid=0,
//   out_data=RESET_VAL, in_ready=1 once flush drops.
// - CNT_W=4; hold backpressure 20 cycles -> stall_cnt sticks at 15.
// - Mid-stream rst=1 for 1 cycle -> all outputs at reset values the next cycle; no old payload ever emerges.
// - PIPE_STAGE_SKID_EN defined; out_ready drops during streaming -> exactly one extra payload accepted,
//   none lost or duplicated.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: stage payload types, default counter width and saturating increment
package pipe_pkg;
    localparam int PIPE_CNT_W_DEF = 16;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;
    function automatic logic [63:0] pipe_sat_inc(input logic [63:0] v, input int w);
        return (v >= (64'd1 << w) - 64'd1) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one {valid, payload} pipeline slot with load, clear and hold
module pipe_stage_slot #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    always_comb begin
        valid_d = clr ? 1'b0 : ld ? d_valid : valid_q;
        data_d  = clr ? RESET_VAL : ld ? d_data : data_q;
    end
    always_ff @(posedge clk) begin
        valid_q <= rst ? 1'b0 : valid_d;
        data_q  <= rst ? RESET_VAL : data_d;
    end
    assign q_valid = valid_q;
    assign q_data  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-slot valid/ready pipeline register with freeze, flush, stall/bubble counters; optional skid via PIPE_STAGE_SKID_EN
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = PIPE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             freeze,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] p [DEPTH];
    logic             acc, src_v;
    logic [WIDTH-1:0] src_data;
    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) rdy[i] = !freeze && (!v[i] || rdy[i+1]);
    end
`ifdef PIPE_STAGE_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    assign in_ready = !skid_v_q && !rst;
    // A held skid entry always feeds slot 0 ahead of new input
    always_comb begin
        acc         = in_valid && in_ready;
        src_v       = skid_v_q || acc;
        src_data    = skid_v_q ? skid_data_q : in_data;
        skid_v_d    = flush ? 1'b0 : src_v && !rdy[0];
        skid_data_d = (!skid_v_q && acc && !rdy[0]) ? in_data : skid_data_q;
    end
    always_ff @(posedge clk) begin
        skid_v_q    <= rst ? 1'b0 : skid_v_d;
        skid_data_q <= rst ? RESET_VAL : skid_data_d;
    end
`else
    assign in_ready = rdy[0] && !flush && !rst;
    always_comb begin
        acc      = in_valid && in_ready;
        src_v    = acc;
        src_data = in_data;
    end
`endif
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_head
            pipe_stage_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_slot (
                .clk(clk), .rst(rst), .clr(flush), .ld(rdy[g]),
                .d_valid(src_v), .d_data(src_data), .q_valid(v[g]), .q_data(p[g])
            );
        end else begin : g_body
            pipe_stage_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_slot (
                .clk(clk), .rst(rst), .clr(flush), .ld(rdy[g]),
                .d_valid(v[g-1]), .d_data(p[g-1]), .q_valid(v[g]), .q_data(p[g])
            );
        end
    end
    assign out_valid = v[DEPTH-1];
    assign out_data  = p[DEPTH-1];
    always_comb begin
        stall_d  = (out_valid && (!out_ready || freeze)) ? CNT_W'(pipe_sat_inc(64'(stall_q), CNT_W)) : stall_q;
        bubble_d = (!out_valid && !freeze) ? CNT_W'(pipe_sat_inc(64'(bubble_q), CNT_W)) : bubble_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a shift-chain reference model
module tb_pipe_stage_reg;
    localparam int           D    = 3;
    localparam int           W    = 32;
    localparam int           CW   = 4;
    localparam int           CMAX = (1 << CW) - 1;
    localparam logic [W-1:0] RV   = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_ready, freeze, flush, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [CW-1:0] stall_cnt, bubble_cnt;
    logic          a_iv, a_ir, a_ov, a_ordy;
    logic [31:0]   a_id, a_od;
    logic [15:0]   a_sc, a_bc;

    pipe_stage_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .freeze(freeze), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.WIDTH(32), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .freeze(1'b0), .flush(1'b0), .out_valid(a_ov), .out_ready(a_ordy),
        .out_data(a_od), .stall_cnt(a_sc), .bubble_cnt(a_bc)
    );

    int           checks = 0;
    int           failures = 0;
    bit           mv [D];
    logic [W-1:0] md [D];
    int           ms, mb;
    bit           sv;
    logic [W-1:0] sd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < D; i++) begin
            mv[i] = 1'b0;
            md[i] = RV;
        end
        ms = 0;
        mb = 0;
        sv = 1'b0;
        sd = RV;
    endtask

    // One clock: drive, compare against the model, advance the model, pass the edge
    task automatic cyc(input bit iv, input logic [W-1:0] id, input bit ordy, input bit frz, input bit fl, input bit r);
        bit           ov, rdy0, exp_ir, acc, srcv;
        logic [W-1:0] srcd;
        int           hole;
        in_valid = iv; in_data = id; out_ready = ordy; freeze = frz; flush = fl; rst = r;
        #1;
        ov = mv[D-1];
        hole = -1;
        if (ordy) hole = D - 1;
        else for (int j = 0; j < D; j++) if (!mv[j]) hole = j;
        rdy0 = !frz && hole >= 0;
`ifdef PIPE_STAGE_SKID_EN
        exp_ir = !r && !sv;
`else
        exp_ir = !r && !fl && rdy0;
`endif
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(ov));
        chk("out_data", 64'(out_data), 64'(md[D-1]));
        chk("stall_cnt", 64'(stall_cnt), 64'(ms));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(mb));
        acc = iv && exp_ir;
        srcv = acc;
        srcd = id;
        if (sv) begin
            srcv = 1'b1;
            srcd = sd;
        end
        if (r) mreset();
        else begin
            if (ov && (!ordy || frz) && ms < CMAX) ms++;
            if (!ov && !frz && mb < CMAX) mb++;
            if (fl) begin
                for (int i = 0; i < D; i++) begin
                    mv[i] = 1'b0;
                    md[i] = RV;
                end
                sv = 1'b0;
            end else begin
`ifdef PIPE_STAGE_SKID_EN
                if (rdy0) sv = 1'b0;
                else if (!sv && acc) begin
                    sv = 1'b1;
                    sd = id;
                end
`endif
                if (rdy0) begin
                    for (int i = hole; i > 0; i--) begin
                        mv[i] = mv[i-1];
                        md[i] = md[i-1];
                    end
                    mv[0] = srcv;
                    md[0] = srcd;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
        a_iv = 1'b0; a_id = '0; a_ordy = 1'b0;
        @(posedge clk);
        #1;
        mreset();
        cyc(1'b1, 32'h1111, 1'b1, 1'b0, 1'b0, 1'b1);
        a_iv = 1'b1; a_id = 32'hDEADBEEF; a_ordy = 1'b1;
        rst = 1'b0;
        #1;
        chk("d1_in_ready", 64'(a_ir), 64'd1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("d1_out_valid", 64'(a_ov), 64'd1);
        chk("d1_out_data", 64'(a_od), 64'hDEADBEEF);
        chk("d1_bubble", 64'(a_bc), 64'd1);
        chk("d1_stall", 64'(a_sc), 64'd0);
        a_iv = 1'b0;
        for (int i = 0; i < 10; i++) cyc(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) cyc(1'b1, W'(32'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall_cnt), 64'(CMAX));
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'h200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_data", 64'(out_data), 64'(RV));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, W'(32'h400 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, W'(32'h600 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, W'(32'h700 + i), i > 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(3) != 0, W'($urandom), $urandom_range(3) != 0,
                $urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(63) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
